sys_ctrl: RTL and testbench

- Command decoder between the UART receiver and the register file.
- Parses received byte frames into register-file write and read transactions.
- For reads, captures the register-file read data and hands it to the UART transmitter through a valid/busy handshake.
- Sole master of the register file's WrEn, RdEn, Address and WrData.

---
 rtl/sys_ctrl_pkg.sv | 19 +
 rtl/sys_ctrl_timer.sv | 30 +++
 rtl/sys_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sys_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared opcodes, default widths and FSM encoding for sys_ctrl
package sys_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADD_W  = 4;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

endpackage

// File: rtl/sys_ctrl_timer.sv
// rtl/sys_ctrl_timer.sv - inter-byte idle counter that flags an abandoned frame
module sys_ctrl_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic Clk,
    input  logic RST_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    // Count idle cycles while a frame is open; saturate at the expiry value
    always_ff @(posedge Clk) begin
        if (!RST_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - UART frame decoder driving the register file (timeout under SYS_CTRL_TIMEOUT_EN)
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADD_W       = DEF_ADD_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              Clk,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdData_Valid,
    input  logic              TX_Busy,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADD_W-1:0]  Address,
    output logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              Cmd_Err
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_wr_en;
    logic               r_rd_en;
    logic [ADD_W-1:0]   r_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_vld;
    logic               r_cmd_err;

    logic               w_wr_en_nxt;
    logic               w_rd_en_nxt;
    logic [ADD_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]  w_wr_data_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [DATA_W-1:0]  w_tx_data_nxt;
    logic               w_tx_vld_nxt;
    logic               w_cmd_err_nxt;
    logic               w_expire;

`ifdef SYS_CTRL_TIMEOUT_EN
    logic w_accept;
    logic w_timer_en;
    logic w_timer_clr;

    // Bytes are consumed in every state except the read-response states
    assign w_accept    = RX_D_VLD && (r_state != RD_WAIT) && (r_state != TX_SEND);
    assign w_timer_en  = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                         (r_state == RD_ADDR) || (r_state == RD_WAIT);
    assign w_timer_clr = w_accept || (w_state_nxt != r_state);

    sys_ctrl_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .Clk      (Clk),
        .RST_n    (RST_n),
        .i_clr    (w_timer_clr),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );
`else
    // No timeout logic: an open frame waits forever
    assign w_expire = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    // State register and registered outputs
    always_ff @(posedge Clk) begin
        if (!RST_n) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_data    <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_data    <= w_data_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_cmd_err <= w_cmd_err_nxt;
        end
    end

    // Frame decode: an arriving byte always wins over a simultaneous timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_addr_nxt    = r_addr;
        w_wr_data_nxt = r_wr_data;
        w_data_nxt    = r_data;
        w_tx_data_nxt = r_tx_data;
        w_tx_vld_nxt  = 1'b0;
        w_cmd_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_W'(WR_CMD)) begin
                        w_state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == DATA_W'(RD_CMD)) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADD_W-1:0];
                    w_state_nxt = WR_DATA;
                end else if (w_expire) begin
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wr_data_nxt = RX_P_DATA;
                    w_wr_en_nxt   = 1'b1;
                    w_state_nxt   = IDLE;
                end else if (w_expire) begin
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADD_W-1:0];
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = RD_WAIT;
                end else if (w_expire) begin
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            RD_WAIT: begin
                if (RdData_Valid) begin
                    w_data_nxt  = RdData;
                    w_state_nxt = TX_SEND;
                end else if (w_expire) begin
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            TX_SEND: begin
                if (!TX_Busy) begin
                    w_tx_vld_nxt  = 1'b1;
                    w_tx_data_nxt = r_data;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_addr;
    assign WrData    = r_wr_data;
    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign Cmd_Err   = r_cmd_err;

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - directed self-checking bench for sys_ctrl
`timescale 1ns/1ps
module tb_sys_ctrl;

    logic       Clk;
    logic       RST_n;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       TX_Busy;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       Cmd_Err;

    int errors = 0;
    int checks = 0;

    sys_ctrl #(
        .DATA_W      (8),
        .ADD_W       (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .Clk          (Clk),
        .RST_n        (RST_n),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_Busy      (TX_Busy),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .Cmd_Err      (Cmd_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge Clk);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    // RdEn is visible in the current cycle; answer in the following one
    task automatic rd_respond(input logic [7:0] d);
        @(posedge Clk);
        #1;
        RdData       = d;
        RdData_Valid = 1'b1;
        @(posedge Clk);
        #1;
        RdData_Valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        tick(2);
        checks++; if (WrEn !== 1'b0)     begin errors++; $display("FAIL reset_wren got=%b exp=0", WrEn); end
        checks++; if (RdEn !== 1'b0)     begin errors++; $display("FAIL reset_rden got=%b exp=0", RdEn); end
        checks++; if (Address !== 4'h0)  begin errors++; $display("FAIL reset_addr got=%h exp=0", Address); end
        checks++; if (WrData !== 8'h00)  begin errors++; $display("FAIL reset_wrdata got=%h exp=00", WrData); end
        checks++; if (TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", TX_P_DATA); end
        checks++; if (TX_D_VLD !== 1'b0) begin errors++; $display("FAIL reset_txvld got=%b exp=0", TX_D_VLD); end
        checks++; if (Cmd_Err !== 1'b0)  begin errors++; $display("FAIL reset_cmderr got=%b exp=0", Cmd_Err); end
        RST_n = 1'b1;
        tick(1);
    endtask

    task automatic test_write();
        send_byte(8'hAA);
        send_byte(8'h05);
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL wr_early_wren got=%b exp=0", WrEn); end
        send_byte(8'h3C);
        checks++; if (WrEn !== 1'b1 || RdEn !== 1'b0) begin errors++; $display("FAIL wr_pulse wren=%b rden=%b exp=1/0", WrEn, RdEn); end
        checks++; if (Address !== 4'h5 || WrData !== 8'h3C) begin errors++; $display("FAIL wr_addr_data got=%h/%h exp=5/3c", Address, WrData); end
        tick(1);
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL wr_single_cycle got=%b exp=0", WrEn); end
        checks++; if (Address !== 4'h5 || WrData !== 8'h3C) begin errors++; $display("FAIL wr_hold got=%h/%h exp=5/3c", Address, WrData); end
        tick(2);
    endtask

    task automatic test_read();
        send_byte(8'hBB);
        send_byte(8'h02);
        checks++; if (RdEn !== 1'b1 || WrEn !== 1'b0 || Address !== 4'h2) begin errors++; $display("FAIL rd_pulse rden=%b wren=%b addr=%h exp=1/0/2", RdEn, WrEn, Address); end
        rd_respond(8'h81);
        checks++; if (TX_D_VLD !== 1'b0 || RdEn !== 1'b0) begin errors++; $display("FAIL rd_tx_early txvld=%b rden=%b exp=0/0", TX_D_VLD, RdEn); end
        tick(1);
        checks++; if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h81) begin errors++; $display("FAIL rd_tx got=%b/%h exp=1/81", TX_D_VLD, TX_P_DATA); end
        tick(1);
        checks++; if (TX_D_VLD !== 1'b0) begin errors++; $display("FAIL rd_tx_single got=%b exp=0", TX_D_VLD); end
        tick(2);
    endtask

    task automatic test_backpressure();
        bit bad_vld = 0;
        bit bad_err = 0;
        TX_Busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h02);
        rd_respond(8'hC3);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'h55);
            else tick(1);
            if (TX_D_VLD !== 1'b0) bad_vld = 1;
            if (Cmd_Err !== 1'b0)  bad_err = 1;
        end
        checks++; if (bad_vld) begin errors++; $display("FAIL bp_hold txvld seen=1 exp=0"); end
        checks++; if (bad_err) begin errors++; $display("FAIL bp_stray cmderr seen=1 exp=0"); end
        TX_Busy = 1'b0;
        tick(1);
        checks++; if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hC3) begin errors++; $display("FAIL bp_release got=%b/%h exp=1/c3", TX_D_VLD, TX_P_DATA); end
        tick(1);
        checks++; if (TX_D_VLD !== 1'b0) begin errors++; $display("FAIL bp_single got=%b exp=0", TX_D_VLD); end
        tick(2);
    endtask

    task automatic test_bad_opcode();
        send_byte(8'h12);
        checks++; if (Cmd_Err !== 1'b1) begin errors++; $display("FAIL bad_op_err got=%b exp=1", Cmd_Err); end
        tick(1);
        checks++; if (Cmd_Err !== 1'b0) begin errors++; $display("FAIL bad_op_single got=%b exp=0", Cmd_Err); end
        send_byte(8'hAA);
        send_byte(8'hF7);
        send_byte(8'h11);
        checks++; if (WrEn !== 1'b1 || Address !== 4'h7 || WrData !== 8'h11) begin errors++; $display("FAIL trunc_wr got=%b/%h/%h exp=1/7/11", WrEn, Address, WrData); end
        tick(2);
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hAA);
        send_byte(8'h03);
        RST_n = 1'b0;
        tick(1);
        RST_n = 1'b1;
        checks++; if (Address !== 4'h0 || WrData !== 8'h00 || WrEn !== 1'b0) begin errors++; $display("FAIL rst_mid_clear got=%h/%h/%b exp=0/00/0", Address, WrData, WrEn); end
        send_byte(8'h44);
        checks++; if (Cmd_Err !== 1'b1 || WrEn !== 1'b0) begin errors++; $display("FAIL rst_mid_44 cmderr=%b wren=%b exp=1/0", Cmd_Err, WrEn); end
        tick(2);
    endtask

    task automatic test_back_to_back();
        send_byte(8'hAA);
        send_byte(8'h0A);
        send_byte(8'h99);
        checks++; if (WrEn !== 1'b1 || Address !== 4'hA || WrData !== 8'h99) begin errors++; $display("FAIL b2b_wr got=%b/%h/%h exp=1/a/99", WrEn, Address, WrData); end
        send_byte(8'hBB);
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL b2b_wr_single got=%b exp=0", WrEn); end
        send_byte(8'h0C);
        checks++; if (RdEn !== 1'b1 || Address !== 4'hC) begin errors++; $display("FAIL b2b_rd got=%b/%h exp=1/c", RdEn, Address); end
        rd_respond(8'h6E);
        tick(1);
        checks++; if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h6E) begin errors++; $display("FAIL b2b_tx got=%b/%h exp=1/6e", TX_D_VLD, TX_P_DATA); end
        tick(2);
    endtask

`ifdef SYS_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int  n = 0;
        bit  seen = 0;
        bit  rd_seen = 0;
        send_byte(8'hBB);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            n++;
            if (RdEn === 1'b1) rd_seen = 1;
            if (Cmd_Err === 1'b1) seen = 1;
        end
        checks++; if (!seen || n != 16) begin errors++; $display("FAIL timeout_err seen=%0d cycles=%0d exp=1/16", seen, n); end
        checks++; if (rd_seen) begin errors++; $display("FAIL timeout_rden seen=1 exp=0"); end
        send_byte(8'hBB);
        send_byte(8'h09);
        checks++; if (RdEn !== 1'b1 || Address !== 4'h9) begin errors++; $display("FAIL timeout_next_rd got=%b/%h exp=1/9", RdEn, Address); end
        rd_respond(8'h27);
        tick(1);
        checks++; if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h27) begin errors++; $display("FAIL timeout_next_tx got=%b/%h exp=1/27", TX_D_VLD, TX_P_DATA); end
        tick(2);
    endtask
`endif

    initial begin
        RST_n        = 1'b0;
        RX_P_DATA    = 8'h00;
        RX_D_VLD     = 1'b0;
        RdData       = 8'h00;
        RdData_Valid = 1'b0;
        TX_Busy      = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_bad_opcode();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SYS_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
